result_reader: RTL and testbench
================================

Name: result_reader

Overview:
- Read-side counterpart of the multiplier controller's result write path (`wr_ram`).
- After the controller pulses `done`, this block reads every result word out of the result RAM in address order.
- Each word is presented on a valid/ready output stream to the downstream consumer (testbench monitor or host interface).
- Tags the final word and signals completion of the drain.

Parameters:
- DATA_W, 32, width of one result word (16x16 product).
- ADDR_W, 4, result RAM address width.
- COUNT, 16, number of result words to drain per run; legal range 1..2^ADDR_W.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- done_in, input, 1, one-cycle pulse from the multiplier controller: all results written.
- rd_en, output, 1, result RAM read enable.
- rd_addr, output, ADDR_W, result RAM read address.
- rd_data, input, DATA_W, result RAM read data; valid the cycle after rd_en is high (synchronous RAM).
- out_data, output, DATA_W, streamed result word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, consumer accepts the word when out_valid and out_ready are both high at a rising edge.
- out_last, output, 1, high with out_valid on the word from address COUNT-1.
- busy, output, 1, high in every state except IDLE.
- finished, output, 1, one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, addr=0, out_data=0.
  - rd_en, out_valid, out_last, busy and finished are all 0.
  - Outputs are 0 while rst_n is held low.
- States: IDLE, RD, CAP, SEND, FIN (registered state; Moore outputs).
- IDLE:
  - All outputs 0.
  - If done_in is high: addr<=0, go to RD. Otherwise stay.
- RD:
  - rd_en=1, rd_addr=addr.
  - Always go to CAP.
- CAP:
  - rd_en=0.
  - out_data<=rd_data at the exiting edge; go to SEND.
- SEND:
  - out_valid=1; out_last=1 iff addr==COUNT-1.
  - If out_ready is low: stay; out_data, out_last and addr are held stable.
  - If out_ready is high and addr==COUNT-1: go to FIN.
  - If out_ready is high otherwise: addr<=addr+1, go to RD.
- FIN:
  - finished=1 for exactly one cycle.
  - Go to IDLE.
- busy=1 in RD, CAP, SEND and FIN.
- Latency:
  - done_in sampled at edge E -> rd_en high in the cycle after E -> out_valid high from the 3rd cycle after E.
  - With out_ready held high, one word is accepted every 3 cycles.
  - The last accept is followed by finished in the next cycle.
- rd_addr holds the addr value when rd_en=0 (don't-care for the RAM, but deterministic).
- done_in while busy: ignored; no restart and no queued second run.
- done_in high in the FIN cycle: ignored. A new run starts only when done_in is sampled in IDLE.
- COUNT=1: the first word carries out_last=1; FIN follows its accept.
- addr never exceeds COUNT-1, so there is no wrap; the increment is ADDR_W bits wide.
- out_valid never drops without a handshake; no word is skipped or duplicated.
- Reset mid-operation: immediate return to IDLE with all outputs 0.
  - No finished pulse is produced.
  - The partially drained run is abandoned.

Test Plan:
- COUNT=4; RAM holds 0x00000001, 0x0000FFFE, 0x12345678, 0xFFFFFFFF; out_ready=1; pulse done_in:
  - 4 words stream in order, 3 cycles apart.
  - out_last is high only on 0xFFFFFFFF.
  - finished pulses 1 cycle after the last accept; busy returns to 0.
- Same RAM; out_ready low for 5 cycles at word 2, then high:
  - 0x0000FFFE is held stable with out_valid=1 for the whole stall.
  - The word is accepted exactly once; addr does not advance during the stall.
- Pulse done_in again while busy at word 1:
  - Still exactly 4 words and one finished pulse.
- Pull rst_n low during SEND of word 2:
  - out_valid, busy and finished go to 0 immediately; no finished pulse.
  - A later done_in restarts from address 0.
- COUNT=1, RAM[0]=0xA5A5A5A5, done_in pulse:
  - A single word with out_last=1, followed by finished.
- Two done_in pulses separated by a full run:
  - The second run rereads from address 0.
  - Total of 2×COUNT words and 2 finished pulses.

Source files
------------

// File: rtl/result_reader.sv
// Drains the result RAM after the multiplier controller signals done, streaming
// each word in address order on a valid/ready interface and tagging the last one.
module result_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int COUNT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              finished
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COUNT - 1);

    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;

    assign rd_addr = addr;

    // Outputs are registered alongside the state so each one equals the decode of the state it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            out_data  <= '0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (done_in) begin
                        addr  <= '0;
                        state <= RD;
                        rd_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                RD: begin
                    state <= CAP;
                    rd_en <= 1'b0;
                end
                CAP: begin
                    out_data  <= rd_data;
                    state     <= SEND;
                    out_valid <= 1'b1;
                    out_last  <= (addr == LAST);
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (addr == LAST) begin
                            state    <= FIN;
                            finished <= 1'b1;
                        end else begin
                            addr  <= addr + ADDR_W'(1);
                            state <= RD;
                            rd_en <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    finished <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    rd_en     <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    finished  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: table-driven stream checks, stall/reset/restart
// sequences, and randomized runs scored against an expected-stream model.
module tb_result_reader;
    localparam int DW = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic done4 = 1'b0, ready4 = 1'b1;
    logic done1 = 1'b0, ready1 = 1'b1;

    logic          rd_en4, out_valid4, out_last4, busy4, finished4;
    logic [AW-1:0] rd_addr4;
    logic [DW-1:0] rd_data4, out_data4;
    logic          rd_en1, out_valid1, out_last1, busy1, finished1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1, out_data1;

    logic [DW-1:0] ram4 [16];
    logic [DW-1:0] ram1 [16];

    result_reader #(.DATA_W(DW), .ADDR_W(AW), .COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .done_in(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .out_data(out_data4), .out_valid(out_valid4), .out_ready(ready4),
        .out_last(out_last4), .busy(busy4), .finished(finished4));

    result_reader #(.DATA_W(DW), .ADDR_W(AW), .COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .done_in(done1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(ready1),
        .out_last(out_last1), .busy(busy1), .finished(finished1));

    // Synchronous RAM models: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en4) rd_data4 <= ram4[rd_addr4];
        if (rd_en1) rd_data1 <= ram1[rd_addr1];
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: records accepted words and finished pulses; checks last tagging and stall stability.
    logic [DW-1:0] got4 [$];
    int            fins4 = 0;
    logic          prev_v = 1'b0, prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("stall_valid", {63'd0, out_valid4}, 64'd1);
                check("stall_data", {32'd0, out_data4}, {32'd0, prev_d});
            end
            if (out_valid4 && ready4) begin
                check("last_tag", {63'd0, out_last4}, {63'd0, (got4.size() % 4) == 3});
                got4.push_back(out_data4);
            end
            if (finished4) fins4++;
            prev_v = out_valid4;
            prev_r = ready4;
            prev_d = out_data4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse4();
        done4 = 1'b1;
        tick();
        done4 = 1'b0;
    endtask

    task automatic wait_valid4(input string name);
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid4) begin ok = 1; break; end
            tick();
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_fin4(input string name);
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (finished4) begin ok = 1; break; end
            tick();
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
        tick();
    endtask

    function automatic void check_stream(string name, int runs);
        check({name, "_count"}, 64'(got4.size()), 64'(4 * runs));
        for (int i = 0; i < got4.size() && i < 4 * runs; i++)
            check({name, "_word"}, {32'd0, got4[i]}, {32'd0, ram4[i % 4]});
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int t0, f0;
        vecs[0] = '{32'h0000_0001, 1'b0};
        vecs[1] = '{32'h0000_FFFE, 1'b0};
        vecs[2] = '{32'h1234_5678, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1};
        for (int i = 0; i < 16; i++) begin ram4[i] = 32'hDEAD_0000 + 32'(i); ram1[i] = 32'hBEEF_0000 + 32'(i); end
        for (int i = 0; i < 4; i++) ram4[i] = vecs[i].data;
        ram1[0] = 32'hA5A5_A5A5;

        // Reset state
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_outs4", {58'd0, rd_en4, out_valid4, out_last4, busy4, finished4, 1'b0}, 64'd0);
        check("rst_data4", {32'd0, out_data4}, 64'd0);
        check("rst_addr4", {60'd0, rd_addr4}, 64'd0);
        check("rst_outs1", {59'd0, rd_en1, out_valid1, out_last1, busy1, finished1}, 64'd0);
        rst_n = 1'b1;
        tick(); tick();
        check("idle_busy", {63'd0, busy4}, 64'd0);

        // Table-driven stream with ready held high
        got4.delete(); fins4 = 0;
        pulse4();
        check("rd_en_lat", {63'd0, rd_en4}, 64'd1);
        check("rd_addr0", {60'd0, rd_addr4}, 64'd0);
        check("busy_run", {63'd0, busy4}, 64'd1);
        tick(); tick();
        check("valid_lat", {63'd0, out_valid4}, 64'd1);
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_valid4("tbl");
            if (i > 0) check("tbl_gap", 64'(cyc - t0), 64'd3);
            t0 = cyc;
            check("tbl_data", {32'd0, out_data4}, {32'd0, vecs[i].data});
            check("tbl_last", {63'd0, out_last4}, {63'd0, vecs[i].last});
            tick();
        end
        check("fin_pulse", {63'd0, finished4}, 64'd1);
        check("fin_busy", {63'd0, busy4}, 64'd1);
        done4 = 1'b1;  // sampled in FIN: must be ignored
        tick();
        done4 = 1'b0;
        check("fin_drop", {63'd0, finished4}, 64'd0);
        check("idle_after", {63'd0, busy4}, 64'd0);
        tick(); tick();
        check("fin_done_ignored", {63'd0, busy4 | rd_en4}, 64'd0);
        check_stream("tbl", 1);
        check("tbl_fins", 64'(fins4), 64'd1);

        // Stall on word 2 for 5 cycles
        got4.delete(); fins4 = 0;
        pulse4();
        wait_valid4("stall0");
        tick();
        ready4 = 1'b0;
        wait_valid4("stall1");
        for (int k = 0; k < 5; k++) begin
            check("stall_hold_data", {32'd0, out_data4}, 64'h0000_FFFE);
            check("stall_addr", {60'd0, rd_addr4}, 64'd1);
            tick();
        end
        ready4 = 1'b1;
        tick();
        check("stall_once", {63'd0, out_valid4}, 64'd0);
        wait_fin4("stall");
        check_stream("stall", 1);
        check("stall_fins", 64'(fins4), 64'd1);

        // done_in while busy is ignored
        got4.delete(); fins4 = 0;
        pulse4();
        pulse4();
        wait_valid4("busy0");
        tick();
        wait_valid4("busy1");
        pulse4();
        wait_fin4("busy");
        tick(); tick(); tick(); tick();
        check_stream("busy", 1);
        check("busy_fins", 64'(fins4), 64'd1);
        check("busy_idle", {63'd0, busy4}, 64'd0);

        // Reset during SEND of word 2
        got4.delete(); fins4 = 0;
        pulse4();
        wait_valid4("rst0");
        tick();
        ready4 = 1'b0;
        wait_valid4("rst1");
        rst_n = 1'b0;
        #1;
        check("rst_mid", {61'd0, out_valid4, busy4, finished4}, 64'd0);
        tick(); tick();
        ready4 = 1'b1;
        rst_n = 1'b1;
        tick(); tick();
        check("rst_no_fin", 64'(fins4), 64'd0);
        got4.delete();
        pulse4();
        check("rst_restart_addr", {60'd0, rd_addr4}, 64'd0);
        wait_fin4("rst");
        check_stream("rst", 1);
        check("rst_fins", 64'(fins4), 64'd1);

        // COUNT=1
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        tick(); tick();
        check("c1_valid", {63'd0, out_valid1}, 64'd1);
        check("c1_data", {32'd0, out_data1}, 64'hA5A5_A5A5);
        check("c1_last", {63'd0, out_last1}, 64'd1);
        tick();
        check("c1_fin", {62'd0, finished1, out_valid1}, 64'd2);
        tick();
        check("c1_idle", {62'd0, busy1, finished1}, 64'd0);

        // Two back-to-back runs reread from address 0
        got4.delete(); fins4 = 0;
        pulse4();
        wait_fin4("two_a");
        pulse4();
        wait_fin4("two_b");
        check_stream("two", 2);
        check("two_fins", 64'(fins4), 64'd2);

        // Randomized runs: random data, random back-pressure, stray done_in while busy
        for (int r = 0; r < 20; r++) begin
            bit ok = 0;
            for (int i = 0; i < 4; i++) ram4[i] = $urandom;
            got4.delete(); fins4 = 0;
            pulse4();
            for (int k = 0; k < 400; k++) begin
                if (finished4) begin ok = 1; break; end
                ready4 = ($urandom_range(0, 3) != 0);
                done4  = busy4 && ($urandom_range(0, 7) == 0);
                tick();
            end
            done4 = 1'b0;
            ready4 = 1'b1;
            if (!ok) check("rand_timeout", 64'd0, 64'd1);
            tick(); tick();
            t0 = tests; f0 = fails;
            check_stream("rand", 1);
            check("rand_fins", 64'(fins4), 64'd1);
            check("rand_idle", {63'd0, busy4}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
